dmem_host_arbiter: RTL and testbench

- Sits between riscv_cpu's data port and data_mem and arbitrates the single data-memory port between the CPU and an external host.
- The host gets a valid/ready load session for writes and readback, with optional address auto-increment (word stride).
- While a session is open the CPU is held in reset via cpu_hold.
- Sessions can be opened after reset or mid-run; this gives multi-session, handshaked, readback-capable loading.

---
 rtl/dmem_host_arbiter_if.sv | 43 ++++
 rtl/dmem_host_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_host_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_host_arbiter_if.sv
// Bundle of the host load port, the CPU data port and the data_mem port.
// The arbiter sits on the slave side; the surrounding system (CPU, host,
// memory) sits on the master side.
interface dmem_host_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
);
  logic              host_load_req;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic              host_autoinc;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              cpu_hold;
  logic              cpu_memwrite;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  load_count;
  logic [1:0]        state_dbg;

  modport slave (
    input  host_load_req, host_valid, host_we, host_autoinc, host_addr, host_wdata,
    input  cpu_memwrite, cpu_addr, cpu_wdata, mem_rdata,
    output host_ready, host_rdata, host_rvalid, cpu_hold, cpu_rdata,
    output mem_we, mem_addr, mem_wdata, load_count, state_dbg
  );

  modport master (
    output host_load_req, host_valid, host_we, host_autoinc, host_addr, host_wdata,
    output cpu_memwrite, cpu_addr, cpu_wdata, mem_rdata,
    input  host_ready, host_rdata, host_rvalid, cpu_hold, cpu_rdata,
    input  mem_we, mem_addr, mem_wdata, load_count, state_dbg
  );
endinterface

// File: rtl/dmem_host_arbiter.sv
// Shares the single data_mem port between the CPU and an external host.
// While a host load session is open the CPU is held in reset.
//
// Host handshake: a beat transfers on a rising edge where host_valid and
// host_ready are both 1. host_ready is 1 only while a session is open and
// does not depend on host_valid. Write beats drive data_mem combinationally
// in the accept cycle; read beats return data on host_rdata with a
// one-cycle host_rvalid pulse in the cycle after the accept.
module dmem_host_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 8,
  parameter int ADDR_STEP = 4
) (
  input logic clk,
  input logic reset,
  dmem_host_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] beatAddr;
  logic [CNT_W-1:0]  loadCount;
  logic [DATA_W-1:0] hostRdata;
  logic              hostRvalid;
  logic              beatAccept;
  logic              enterLoad;

  assign beatAddr   = bus.host_autoinc ? ptr : bus.host_addr;
  assign beatAccept = (state == LOAD) && bus.host_valid;
  assign enterLoad  = (state != LOAD) && (nextState == LOAD);

  // State register; reset lands in HOLD immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HOLD;
    else       state <= nextState;
  end

  // Next state and port steering; the CPU owns the memory port only in RUN.
  always_comb begin
    nextState     = state;
    bus.cpu_hold  = 1'b1;
    bus.host_ready = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.host_addr;
    bus.mem_wdata = bus.host_wdata;
    unique case (state)
      HOLD: begin
        nextState = bus.host_load_req ? LOAD : RELEASE;
      end
      LOAD: begin
        bus.host_ready = 1'b1;
        bus.mem_addr   = beatAddr;
        bus.mem_we     = bus.host_valid && bus.host_we;
        if (!bus.host_load_req) nextState = RELEASE;
      end
      RELEASE: begin
        // One dead cycle so the last host write is committed before the CPU runs.
        nextState = RUN;
      end
      RUN: begin
        bus.cpu_hold  = 1'b0;
        bus.mem_we    = bus.cpu_memwrite;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        if (bus.host_load_req) nextState = LOAD;
      end
      default: nextState = HOLD;
    endcase
  end

  // Session pointer, beat counter and registered read-back data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      loadCount  <= '0;
      hostRdata  <= '0;
      hostRvalid <= 1'b0;
    end else begin
      hostRvalid <= beatAccept && !bus.host_we;
      if (beatAccept && !bus.host_we) hostRdata <= bus.mem_rdata;
      if (enterLoad) begin
        ptr       <= bus.host_addr;
        loadCount <= '0;
      end else if (beatAccept) begin
        ptr <= beatAddr + ADDR_W'(ADDR_STEP);
        if (loadCount != {CNT_W{1'b1}}) loadCount <= loadCount + CNT_W'(1);
      end
    end
  end

  assign bus.host_rdata  = hostRdata;
  assign bus.host_rvalid = hostRvalid;
  assign bus.load_count  = loadCount;
  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_dmem_host_arbiter.sv
// Bench for dmem_host_arbiter: directed scenarios plus randomized host
// sessions checked against a word-level memory/pointer/counter model.
module tb_dmem_host_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  dmem_host_arbiter_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(8)) bus();

  dmem_host_arbiter #(.DATA_W(32), .ADDR_W(32), .CNT_W(8), .ADDR_STEP(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // data_mem stand-in: 1024 words, combinational read, write on rising edge
  logic        memClear;
  logic [31:0] envMem [0:1023];
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 1024; i++) envMem[i] <= 32'h0;
    end else if (bus.mem_we) begin
      envMem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = envMem[bus.mem_addr[11:2]];

  // Reference model state
  logic [31:0] exp_q[$];
  logic [31:0] refMem [0:1023];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic idle();
    bus.host_valid   = 1'b0;
    bus.host_we      = 1'b0;
    bus.host_autoinc = 1'b0;
    bus.host_wdata   = 32'h0;
    bus.cpu_memwrite = 1'b0;
    bus.cpu_addr     = 32'h0;
    bus.cpu_wdata    = 32'h0;
  endtask

  task automatic apply_reset(input logic req, input logic [31:0] addr);
    @(negedge clk);
    reset = 1'b1;
    bus.host_load_req = req;
    bus.host_addr = addr;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.host_load_req = 1'b1;
    bus.host_addr = 32'h1234_5670;
    idle();
    #1;
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_cpu_hold: got %0b expected 1", bus.cpu_hold); end
    checks++; if (bus.host_ready !== 1'b0) begin failures++; $display("FAIL rst_host_ready: got %0b expected 0", bus.host_ready); end
    checks++; if (bus.host_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %0b expected 0", bus.host_rvalid); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %0b expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h1234_5670) begin failures++; $display("FAIL rst_mem_addr: got %h expected 12345670", bus.mem_addr); end
    checks++; if (bus.load_count !== 8'd0) begin failures++; $display("FAIL rst_load_count: got %0d expected 0", bus.load_count); end
    checks++; if (bus.host_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", bus.host_rdata); end
  endtask

  task automatic test_write_session();
    @(negedge clk);
    bus.host_addr = 32'h100;
    bus.host_load_req = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (bus.host_ready !== 1'b0 || bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL hold_cycle: got ready=%0b hold=%0b expected ready=0 hold=1", bus.host_ready, bus.cpu_hold); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_autoinc = 1'b1;
      bus.host_addr = 32'h3F0; bus.host_wdata = 32'hA + 32'(i);
      #1;
      checks++; if (bus.host_ready !== 1'b1 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL wr_beat%0d_we: got ready=%0b we=%0b expected 1 1", i, bus.host_ready, bus.mem_we); end
      checks++; if (bus.mem_addr !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL wr_beat%0d_addr: got %h expected %h", i, bus.mem_addr, 32'h100 + 32'(4 * i)); end
      checks++; if (bus.mem_wdata !== 32'hA + 32'(i)) begin failures++; $display("FAIL wr_beat%0d_data: got %h expected %h", i, bus.mem_wdata, 32'hA + 32'(i)); end
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.load_count !== 8'd3) begin failures++; $display("FAIL wr_load_count: got %0d expected 3", bus.load_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (envMem[64 + i] !== 32'hA + 32'(i)) begin failures++; $display("FAIL wr_mem%0d: got %h expected %h", i, envMem[64 + i], 32'hA + 32'(i)); end
    end
  endtask

  task automatic test_readback();
    @(negedge clk);
    bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_autoinc = 1'b0; bus.host_addr = 32'h104;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h104) begin failures++; $display("FAIL rd_addr: got we=%0b addr=%h expected we=0 addr=104", bus.mem_we, bus.mem_addr); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.host_rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid: got %0b expected 1", bus.host_rvalid); end
    checks++; if (bus.host_rdata !== 32'hB) begin failures++; $display("FAIL rd_rdata: got %h expected b", bus.host_rdata); end
    checks++; if (bus.load_count !== 8'd4) begin failures++; $display("FAIL rd_load_count: got %0d expected 4", bus.load_count); end
    @(negedge clk);
    #1;
    checks++; if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 32'hB) begin failures++; $display("FAIL rd_after: got rvalid=%0b rdata=%h expected 0 b", bus.host_rvalid, bus.host_rdata); end
  endtask

  task automatic test_release_timing();
    @(negedge clk);
    bus.host_load_req = 1'b0;
    #1;
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL rel_c0_hold: got %0b expected 1", bus.cpu_hold); end
    @(negedge clk); #1;
    checks++; if (bus.cpu_hold !== 1'b1 || bus.host_ready !== 1'b0) begin failures++; $display("FAIL rel_c1: got hold=%0b ready=%0b expected 1 0", bus.cpu_hold, bus.host_ready); end
    @(negedge clk); #1;
    checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL rel_c2_hold: got %0b expected 0", bus.cpu_hold); end
    checks++; if (bus.load_count !== 8'd4) begin failures++; $display("FAIL rel_count_hold: got %0d expected 4", bus.load_count); end
  endtask

  task automatic test_run_store();
    apply_reset(1'b0, 32'h0);
    #1;
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL run_c1_hold: got %0b expected 1", bus.cpu_hold); end
    @(negedge clk); #1;
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL run_c2_hold: got %0b expected 1", bus.cpu_hold); end
    @(negedge clk); #1;
    checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL run_c3_hold: got %0b expected 0", bus.cpu_hold); end
    bus.cpu_memwrite = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h55;
    #1;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h55) begin failures++; $display("FAIL run_store_port: got we=%0b addr=%h data=%h expected 1 20 55", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    @(negedge clk);
    bus.cpu_memwrite = 1'b0;
    #1;
    checks++; if (envMem[8] !== 32'h55) begin failures++; $display("FAIL run_store_mem: got %h expected 55", envMem[8]); end
    checks++; if (bus.cpu_rdata !== 32'h55) begin failures++; $display("FAIL run_cpu_rdata: got %h expected 55", bus.cpu_rdata); end
  endtask

  task automatic test_run_to_load();
    @(negedge clk);
    bus.host_load_req = 1'b1; bus.host_addr = 32'h200;
    bus.cpu_memwrite = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h77;
    #1;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h40 || bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL r2l_port: got we=%0b addr=%h hold=%0b expected 1 40 0", bus.mem_we, bus.mem_addr, bus.cpu_hold); end
    @(negedge clk);
    bus.cpu_memwrite = 1'b0;
    #1;
    checks++; if (envMem[16] !== 32'h77) begin failures++; $display("FAIL r2l_store: got %h expected 77", envMem[16]); end
    checks++; if (bus.cpu_hold !== 1'b1 || bus.host_ready !== 1'b1) begin failures++; $display("FAIL r2l_load: got hold=%0b ready=%0b expected 1 1", bus.cpu_hold, bus.host_ready); end
    checks++; if (bus.load_count !== 8'd0) begin failures++; $display("FAIL r2l_count: got %0d expected 0", bus.load_count); end
  endtask

  task automatic test_reset_mid_session();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_autoinc = 1'b1; bus.host_wdata = 32'h900 + 32'(i);
    end
    @(negedge clk);
    bus.host_wdata = 32'h902;
    reset = 1'b1;
    #1;
    checks++; if (bus.host_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL mid_rst_ports: got ready=%0b we=%0b hold=%0b expected 0 0 1", bus.host_ready, bus.mem_we, bus.cpu_hold); end
    checks++; if (bus.load_count !== 8'd0 || bus.host_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_regs: got count=%0d rvalid=%0b expected 0 0", bus.load_count, bus.host_rvalid); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (envMem[128] !== 32'h900 || envMem[129] !== 32'h901) begin failures++; $display("FAIL mid_rst_kept: got %h %h expected 900 901", envMem[128], envMem[129]); end
    checks++; if (envMem[130] !== 32'h0) begin failures++; $display("FAIL mid_rst_dropped: got %h expected 0", envMem[130]); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.host_addr = 32'hFFFF_FFFC;
    bus.host_load_req = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_autoinc = 1'b1; bus.host_wdata = 32'hC0 + 32'(i);
      #1;
      checks++; if (bus.mem_addr !== (i == 0 ? 32'hFFFF_FFFC : 32'h0)) begin failures++; $display("FAIL wrap_addr%0d: got %h expected %h", i, bus.mem_addr, (i == 0 ? 32'hFFFF_FFFC : 32'h0)); end
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (envMem[1023] !== 32'hC0 || envMem[0] !== 32'hC1) begin failures++; $display("FAIL wrap_mem: got %h %h expected c0 c1", envMem[1023], envMem[0]); end
    checks++; if (bus.load_count !== 8'd2) begin failures++; $display("FAIL wrap_count: got %0d expected 2", bus.load_count); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_autoinc = 1'b0;
      bus.host_addr = 32'h3F0; bus.host_wdata = 32'(i);
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.load_count !== 8'd255) begin failures++; $display("FAIL sat_count: got %0d expected 255", bus.load_count); end
    bus.host_load_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.cpu_hold !== 1'b0 || bus.load_count !== 8'd255) begin failures++; $display("FAIL sat_close: got hold=%0b count=%0d expected 0 255", bus.cpu_hold, bus.load_count); end
  endtask

  task automatic test_random_sessions();
    logic [31:0] refPtr;
    logic [31:0] a;
    logic [31:0] got;
    int          refCount;
    logic        v, w, beatRead;
    for (int i = 0; i < 1024; i++) refMem[i] = envMem[i];
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      idle();
      refPtr = 32'h800 + 32'(4 * $urandom_range(0, 63));
      bus.host_load_req = 1'b1;
      bus.host_addr = refPtr;
      refCount = 0;
      exp_q.delete();
      @(negedge clk); #1;
      checks++; if (bus.host_ready !== 1'b1 || bus.load_count !== 8'd0) begin failures++; $display("FAIL rnd%0d_open: got ready=%0b count=%0d expected 1 0", s, bus.host_ready, bus.load_count); end
      for (int c = 0; c <= 40; c++) begin
        v = ($urandom_range(0, 3) != 0);
        w = 1'($urandom_range(0, 1));
        bus.host_valid = v;
        bus.host_we = w;
        bus.host_autoinc = 1'($urandom_range(0, 1));
        bus.host_addr = 32'h800 + 32'(4 * $urandom_range(0, 63));
        bus.host_wdata = $urandom;
        if (c == 40) bus.host_load_req = 1'b0;
        a = bus.host_autoinc ? refPtr : bus.host_addr;
        #1;
        checks++; if (bus.mem_addr !== a || bus.mem_we !== (v && w)) begin failures++; $display("FAIL rnd%0d_c%0d_port: got addr=%h we=%0b expected %h %0b", s, c, bus.mem_addr, bus.mem_we, a, v && w); end
        if (v && w) begin
          checks++; if (bus.mem_wdata !== bus.host_wdata) begin failures++; $display("FAIL rnd%0d_c%0d_wdata: got %h expected %h", s, c, bus.mem_wdata, bus.host_wdata); end
        end
        beatRead = v && !w;
        if (v) begin
          if (w) refMem[a[11:2]] = bus.host_wdata;
          else   exp_q.push_back(refMem[a[11:2]]);
          refPtr = a + 32'd4;
          if (refCount < 255) refCount++;
        end
        @(negedge clk); #1;
        checks++; if (bus.host_rvalid !== beatRead) begin failures++; $display("FAIL rnd%0d_c%0d_rvalid: got %0b expected %0b", s, c, bus.host_rvalid, beatRead); end
        if (bus.host_rvalid === 1'b1 && exp_q.size() > 0) begin
          got = exp_q.pop_front();
          checks++; if (bus.host_rdata !== got) begin failures++; $display("FAIL rnd%0d_c%0d_rdata: got %h expected %h", s, c, bus.host_rdata, got); end
        end
        checks++; if (bus.load_count !== 8'(refCount)) begin failures++; $display("FAIL rnd%0d_c%0d_count: got %0d expected %0d", s, c, bus.load_count, refCount); end
      end
      idle();
      checks++; if (bus.host_ready !== 1'b0 || bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL rnd%0d_release: got ready=%0b hold=%0b expected 0 1", s, bus.host_ready, bus.cpu_hold); end
      @(negedge clk); #1;
      checks++; if (bus.cpu_hold !== 1'b0 || bus.load_count !== 8'(refCount)) begin failures++; $display("FAIL rnd%0d_run: got hold=%0b count=%0d expected 0 %0d", s, bus.cpu_hold, bus.load_count, refCount); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd%0d_pending: got %0d expected 0", s, exp_q.size()); end
    end
    for (int i = 512; i < 768; i++) begin
      checks++; if (envMem[i] !== refMem[i]) begin failures++; $display("FAIL rnd_mem%0d: got %h expected %h", i, envMem[i], refMem[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    memClear = 1'b1;
    bus.host_load_req = 1'b0;
    bus.host_addr = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    memClear = 1'b0;
    test_reset();
    test_write_session();
    test_readback();
    test_release_timing();
    test_run_store();
    test_run_to_load();
    test_reset_mid_session();
    test_wrap();
    test_saturate();
    test_random_sessions();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
